// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Brief    : Shared state encoding, vector addresses and stack helpers.
//  Revision : 1.0
// ============================================================================
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PUSH_H = 3'd1,
        ST_PUSH_L = 3'd2,
        ST_PUSH_P = 3'd3,
        ST_VEC_LO = 3'd4,
        ST_VEC_HI = 3'd5,
        ST_LOAD   = 3'd6
    } state_t;

    localparam logic [15:0] VEC_NMI    = 16'hFFFA;
    localparam logic [15:0] VEC_RST    = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ    = 16'hFFFE;
    localparam logic [7:0]  STACK_PAGE = 8'h01;

    // Pushed status always has bit5 set and the break bit (bit4) clear.
    function automatic logic [7:0] push_status(input logic [7:0] p);
        return {p[7:6], 1'b1, 1'b0, p[3:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/nmi_edge.sv
`default_nettype none
// ============================================================================
//  Module   : nmi_edge
//  Brief    : NMI rising-edge detector with a sticky pending flag.
//  Revision : 1.0
// ============================================================================
module nmi_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_nmi,
    input  logic i_clear,
    output logic o_pend
);

    logic r_smp_q;
    logic w_smp_d;
    logic r_pend_q;
    logic w_pend_d;

    // A new edge wins over a simultaneous clear so it is never lost.
    always_comb begin
        w_smp_d  = i_nmi;
        w_pend_d = (i_nmi & ~r_smp_q) | (r_pend_q & ~i_clear);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_smp_q  <= 1'b0;
            r_pend_q <= 1'b0;
        end else begin
            r_smp_q  <= w_smp_d;
            r_pend_q <= w_pend_d;
        end
    end

    assign o_pend = r_pend_q;

endmodule
`default_nettype wire

// File: rtl/int_seq.sv
`default_nettype none
// ============================================================================
//  Module   : int_seq
//  Brief    : Reset/NMI/IRQ sequencer: pushes PC and P, fetches the vector.
//  Revision : 1.0
// ============================================================================
module int_seq
    import cpu_pkg::*;
(
    input  logic        CLK,
    input  logic        R,
    input  logic        NMI,
    input  logic        IRQ,
    input  logic        I_FLAG,
    input  logic        OP_DONE,
    input  logic [15:0] PC_IN,
    input  logic [7:0]  P_IN,
    input  logic [7:0]  SP_IN,
    input  logic [7:0]  DATA_IN,
    output logic        BUSY,
    output logic [15:0] ADDR,
    output logic [7:0]  DATA_OUT,
    output logic        WE,
    output logic [7:0]  PC_LO,
    output logic [7:0]  PC_HI,
    output logic        PC_WR,
    output logic        SP_DEC,
    output logic        SET_I
);

    state_t      r_state_q, w_state_d;
    logic [15:0] r_pc_save_q, w_pc_save_d;
    logic [15:0] r_vec_q, w_vec_d;
    logic [7:0]  r_sp_save_q, w_sp_save_d;
    logic [7:0]  r_lo_q, w_lo_d;
    logic        w_nmi_pend;
    logic        w_take_nmi;
    logic        w_take_irq;

    nmi_edge u_nmi_edge (
        .clk     (CLK),
        .rst     (R),
        .i_nmi   (NMI),
        .i_clear (w_take_nmi),
        .o_pend  (w_nmi_pend)
    );

    always_comb begin
        w_take_nmi  = (r_state_q == ST_IDLE) && OP_DONE && w_nmi_pend;
        w_take_irq  = (r_state_q == ST_IDLE) && OP_DONE && !w_nmi_pend && IRQ && !I_FLAG;
        w_state_d   = r_state_q;
        w_pc_save_d = r_pc_save_q;
        w_sp_save_d = r_sp_save_q;
        w_vec_d     = r_vec_q;
        w_lo_d      = r_lo_q;
        case (r_state_q)
            ST_IDLE: begin
                if (w_take_nmi || w_take_irq) begin
                    w_state_d   = ST_PUSH_H;
                    w_pc_save_d = PC_IN;
                    w_sp_save_d = SP_IN;
                    w_vec_d     = w_take_nmi ? VEC_NMI : VEC_IRQ;
                end
            end
            ST_PUSH_H: w_state_d = ST_PUSH_L;
            ST_PUSH_L: w_state_d = ST_PUSH_P;
            ST_PUSH_P: w_state_d = ST_VEC_LO;
            ST_VEC_LO: w_state_d = ST_VEC_HI;
            ST_VEC_HI: begin
                // DATA_IN here is the low vector byte addressed in VEC_LO.
                w_state_d = ST_LOAD;
                w_lo_d    = DATA_IN;
            end
            ST_LOAD:   w_state_d = ST_IDLE;
            default:   w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (R) begin
            r_state_q   <= ST_VEC_LO;
            r_vec_q     <= VEC_RST;
            r_lo_q      <= 8'h00;
            r_pc_save_q <= 16'h0000;
            r_sp_save_q <= 8'h00;
        end else begin
            r_state_q   <= w_state_d;
            r_vec_q     <= w_vec_d;
            r_lo_q      <= w_lo_d;
            r_pc_save_q <= w_pc_save_d;
            r_sp_save_q <= w_sp_save_d;
        end
    end

    always_comb begin
        BUSY     = (r_state_q != ST_IDLE);
        ADDR     = 16'h0000;
        DATA_OUT = 8'h00;
        WE       = 1'b0;
        SP_DEC   = 1'b0;
        PC_LO    = 8'h00;
        PC_HI    = 8'h00;
        PC_WR    = 1'b0;
        SET_I    = 1'b0;
        case (r_state_q)
            ST_PUSH_H: begin
                ADDR     = {STACK_PAGE, r_sp_save_q};
                DATA_OUT = r_pc_save_q[15:8];
                WE       = 1'b1;
                SP_DEC   = 1'b1;
            end
            ST_PUSH_L: begin
                ADDR     = {STACK_PAGE, r_sp_save_q - 8'd1};
                DATA_OUT = r_pc_save_q[7:0];
                WE       = 1'b1;
                SP_DEC   = 1'b1;
            end
            ST_PUSH_P: begin
                ADDR     = {STACK_PAGE, r_sp_save_q - 8'd2};
                DATA_OUT = push_status(P_IN);
                WE       = 1'b1;
                SP_DEC   = 1'b1;
            end
            ST_VEC_LO: ADDR = r_vec_q;
            ST_VEC_HI: ADDR = r_vec_q + 16'd1;
            ST_LOAD: begin
                PC_LO = r_lo_q;
                PC_HI = DATA_IN;
                PC_WR = 1'b1;
                SET_I = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_int_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_int_seq
//  Brief    : Directed bench for int_seq with a bus-event scoreboard.
//  Revision : 1.0
// ============================================================================
module tb_int_seq;

    logic        CLK = 1'b0;
    logic        R, NMI, IRQ, I_FLAG, OP_DONE;
    logic [15:0] PC_IN;
    logic [7:0]  P_IN, SP_IN, DATA_IN;
    logic        BUSY, WE, PC_WR, SP_DEC, SET_I;
    logic [15:0] ADDR;
    logic [7:0]  DATA_OUT, PC_LO, PC_HI;

    int n_pass = 0;
    int n_tot  = 0;

    logic [23:0] exp_wr[$];
    logic [15:0] exp_rd[$];
    logic [15:0] exp_ld[$];

    int   n;
    logic saw;

    int_seq dut (
        .CLK(CLK), .R(R), .NMI(NMI), .IRQ(IRQ), .I_FLAG(I_FLAG), .OP_DONE(OP_DONE),
        .PC_IN(PC_IN), .P_IN(P_IN), .SP_IN(SP_IN), .DATA_IN(DATA_IN),
        .BUSY(BUSY), .ADDR(ADDR), .DATA_OUT(DATA_OUT), .WE(WE),
        .PC_LO(PC_LO), .PC_HI(PC_HI), .PC_WR(PC_WR), .SP_DEC(SP_DEC), .SET_I(SET_I)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] rom(input logic [15:0] a);
        case (a)
            16'hFFFA: return 8'h11;
            16'hFFFB: return 8'h22;
            16'hFFFC: return 8'h00;
            16'hFFFD: return 8'h80;
            16'hFFFE: return 8'h56;
            16'hFFFF: return 8'h9A;
            default:  return 8'h00;
        endcase
    endfunction

    // Synchronous memory: data for ADDR appears the following cycle.
    always @(posedge CLK) DATA_IN <= rom(ADDR);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (WE === 1'b1) begin
            check("wr_expected", 32'(exp_wr.size() > 0), 32'd1);
            if (exp_wr.size() > 0) check("wr_addr_data", {8'h00, ADDR, DATA_OUT}, {8'h00, exp_wr.pop_front()});
            check("wr_spdec", 32'(SP_DEC), 32'd1);
        end
        if (PC_WR === 1'b1) begin
            check("ld_expected", 32'(exp_ld.size() > 0), 32'd1);
            if (exp_ld.size() > 0) check("ld_pc", {16'h0000, PC_HI, PC_LO}, {16'h0000, exp_ld.pop_front()});
            check("ld_seti", 32'(SET_I), 32'd1);
        end
        if (R === 1'b0 && BUSY === 1'b1 && WE === 1'b0 && PC_WR === 1'b0) begin
            check("rd_expected", 32'(exp_rd.size() > 0), 32'd1);
            if (exp_rd.size() > 0) check("rd_addr", {16'h0000, ADDR}, {16'h0000, exp_rd.pop_front()});
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle(output int cnt);
        int guard;
        cnt   = 0;
        guard = 0;
        @(negedge CLK);
        while (BUSY !== 1'b0 && guard < 20) begin
            cnt++;
            guard++;
            @(negedge CLK);
        end
        if (guard >= 20) check("idle_timeout", 32'(guard), 32'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        R = 1'b1; NMI = 1'b0; IRQ = 1'b0; I_FLAG = 1'b0; OP_DONE = 1'b0;
        PC_IN = 16'h0000; P_IN = 8'h00; SP_IN = 8'h00;

        // Reset hold and release
        step();
        @(negedge CLK);
        check("rst_busy",  32'(BUSY),  32'd1);
        check("rst_addr",  32'(ADDR),  32'hFFFC);
        check("rst_we",    32'(WE),    32'd0);
        check("rst_pcwr",  32'(PC_WR), 32'd0);
        check("rst_seti",  32'(SET_I), 32'd0);
        check("rst_spdec", 32'(SP_DEC),32'd0);
        step();
        exp_rd.push_back(16'hFFFC); exp_rd.push_back(16'hFFFD);
        exp_ld.push_back(16'h8000);
        R = 1'b0;
        wait_idle(n);
        check("rst_len", 32'(n), 32'd3);
        check("idle_addr", 32'(ADDR), 32'h0000);
        check("idle_dout", 32'(DATA_OUT), 32'h00);
        check("idle_we", 32'(WE), 32'd0);

        // Plain IRQ
        PC_IN = 16'h1234; SP_IN = 8'hFD; P_IN = 8'h30; IRQ = 1'b1; OP_DONE = 1'b1;
        exp_wr.push_back({16'h01FD, 8'h12}); exp_wr.push_back({16'h01FC, 8'h34});
        exp_wr.push_back({16'h01FB, 8'h20});
        exp_rd.push_back(16'hFFFE); exp_rd.push_back(16'hFFFF);
        exp_ld.push_back(16'h9A56);
        step();
        IRQ = 1'b0; OP_DONE = 1'b0;
        wait_idle(n);
        check("irq_len", 32'(n), 32'd6);

        // Masked IRQ, then IRQ withdrawn before an instruction boundary
        I_FLAG = 1'b1; IRQ = 1'b1; OP_DONE = 1'b1; saw = 1'b0;
        repeat (10) begin
            @(negedge CLK);
            saw = saw | (BUSY !== 1'b0);
        end
        check("masked_irq", 32'(saw), 32'd0);
        I_FLAG = 1'b0; OP_DONE = 1'b0;
        repeat (2) @(negedge CLK);
        IRQ = 1'b0; OP_DONE = 1'b1; saw = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            saw = saw | (BUSY !== 1'b0);
        end
        check("irq_not_latched", 32'(saw), 32'd0);
        OP_DONE = 1'b0;

        // NMI beats IRQ; second NMI edge during pushes stays pending
        PC_IN = 16'hABCD; SP_IN = 8'h80; P_IN = 8'hC5; IRQ = 1'b1; NMI = 1'b1;
        exp_wr.push_back({16'h0180, 8'hAB}); exp_wr.push_back({16'h017F, 8'hCD});
        exp_wr.push_back({16'h017E, 8'hE5});
        exp_rd.push_back(16'hFFFA); exp_rd.push_back(16'hFFFB);
        exp_ld.push_back(16'h2211);
        step();
        OP_DONE = 1'b1;
        step();
        OP_DONE = 1'b0; IRQ = 1'b0; NMI = 1'b0;
        step();
        NMI = 1'b1;
        step();
        wait_idle(n);
        check("nmi_tail_len", 32'(n), 32'd4);
        NMI = 1'b0; saw = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            saw = saw | (BUSY !== 1'b0);
        end
        check("nmi_wait_boundary", 32'(saw), 32'd0);
        PC_IN = 16'h4321; SP_IN = 8'h7F; P_IN = 8'h00; OP_DONE = 1'b1;
        exp_wr.push_back({16'h017F, 8'h43}); exp_wr.push_back({16'h017E, 8'h21});
        exp_wr.push_back({16'h017D, 8'h20});
        exp_rd.push_back(16'hFFFA); exp_rd.push_back(16'hFFFB);
        exp_ld.push_back(16'h2211);
        step();
        OP_DONE = 1'b0;
        wait_idle(n);
        check("nmi2_len", 32'(n), 32'd6);

        // Stack wrap, then reset during VEC_HI
        PC_IN = 16'h5A5A; SP_IN = 8'h00; P_IN = 8'hFF; IRQ = 1'b1; OP_DONE = 1'b1;
        exp_wr.push_back({16'h0100, 8'h5A}); exp_wr.push_back({16'h01FF, 8'h5A});
        exp_wr.push_back({16'h01FE, 8'hEF});
        exp_rd.push_back(16'hFFFE);
        step();
        IRQ = 1'b0; OP_DONE = 1'b0;
        repeat (4) step();
        R = 1'b1;
        @(negedge CLK);
        check("abort_vechi_addr", 32'(ADDR), 32'hFFFF);
        step();
        @(negedge CLK);
        check("abort_addr", 32'(ADDR), 32'hFFFC);
        check("abort_we", 32'(WE), 32'd0);
        check("abort_pcwr", 32'(PC_WR), 32'd0);
        check("abort_busy", 32'(BUSY), 32'd1);
        step();
        exp_rd.push_back(16'hFFFC); exp_rd.push_back(16'hFFFD);
        exp_ld.push_back(16'h8000);
        R = 1'b0;
        wait_idle(n);
        check("abort_rst_len", 32'(n), 32'd3);

        repeat (2) @(negedge CLK);
        check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
        check("ld_queue_empty", 32'(exp_ld.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
